zero_one_detector: RTL and testbench

Serial sequence detector that asserts Y for one clock period after the bit pair "0" then "1" has been sampled on input A on consecutive rising clock edges. Overlapping detections are allowed. It is a Moore FSM: Y depends only on the registered state. It is a leaf block in the sequence_detector group, fed by a synchronous serial bitstream.

---
 rtl/zero_one_detector_pkg.sv | 12 +
 rtl/zero_one_detector.sv | 35 +++
 tb/tb_zero_one_detector.sv | 117 +++++++++++
 3 files changed

// File: rtl/zero_one_detector_pkg.sv
// rtl/zero_one_detector_pkg.sv - state encoding for the "01" serial detector
package zero_one_detector_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 2'b00,
        S_ZERO   = 2'b01,
        S_DETECT = 2'b10
    } state_t;

endpackage

// File: rtl/zero_one_detector.sv
// rtl/zero_one_detector.sv - Moore FSM flagging a "0" then "1" on serial input A
module zero_one_detector
    import zero_one_detector_pkg::*;
(
    input  logic A,
    input  logic clk,
    input  logic rst,
    output logic Y
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = A ? S_IDLE   : S_ZERO;
            S_ZERO:   w_next = A ? S_DETECT : S_ZERO;
            // A trailing 0 after a detect starts the next pair, so "0101" fires twice
            S_DETECT: w_next = A ? S_IDLE   : S_ZERO;
            default:  w_next = S_IDLE;
        endcase
    end

    assign Y = (r_state == S_DETECT);

endmodule

// File: tb/tb_zero_one_detector.sv
// tb/tb_zero_one_detector.sv - directed and random checks of zero_one_detector
module tb_zero_one_detector;

    logic A;
    logic clk;
    logic rst;
    logic Y;

    int n_cmp;
    int n_bad;
    bit hist[$];

    zero_one_detector dut (
        .A   (A),
        .clk (clk),
        .rst (rst),
        .Y   (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_y();
        if (hist.size() < 2) return 1'b0;
        return (hist[hist.size()-2] == 1'b0) && (hist[hist.size()-1] == 1'b1);
    endfunction

    task automatic check(input string tag, input logic exp);
        n_cmp++;
        assert (Y === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, Y, exp);
        end
    endtask

    task automatic step(input string tag, input bit a);
        @(negedge clk);
        A = a;
        @(posedge clk);
        hist.push_back(a);
        #1;
        check(tag, model_y());
    endtask

    task automatic step_exp(input string tag, input bit a, input logic exp);
        step(tag, a);
        check({tag, "_table"}, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        A = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
    endtask

    task automatic async_pulse(input string tag);
        #1 rst = 1'b1;
        #1;
        check(tag, 1'b0);
        #1 rst = 1'b0;
        hist.delete();
    endtask

    initial begin
        bit pat_a [$];
        logic pat_y [$];

        n_cmp = 0;
        n_bad = 0;
        A = 1'b0;
        rst = 1'b1;
        #1;
        check("reset_async_init", 1'b0);

        do_reset();

        step_exp("basic0", 1'b0, 1'b0);
        step_exp("basic1", 1'b1, 1'b1);

        do_reset();
        pat_a = '{0, 1, 0, 1, 1, 0, 0};
        pat_y = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        foreach (pat_a[i]) step_exp($sformatf("overlap%0d", i), pat_a[i], pat_y[i]);

        do_reset();
        pat_a = '{1, 1, 0, 1, 1, 1};
        pat_y = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        foreach (pat_a[i]) step_exp($sformatf("ones%0d", i), pat_a[i], pat_y[i]);

        do_reset();
        step_exp("mid0", 1'b0, 1'b0);
        step_exp("mid1", 1'b1, 1'b1);
        async_pulse("async_drop");
        step_exp("after_async", 1'b1, 1'b0);

        do_reset();
        pat_a = '{0, 0, 0, 1};
        pat_y = '{1'b0, 1'b0, 1'b0, 1'b1};
        foreach (pat_a[i]) step_exp($sformatf("zeros%0d", i), pat_a[i], pat_y[i]);

        for (int i = 0; i < 300; i++) begin
            step($sformatf("rand%0d", i), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 39) == 0) async_pulse($sformatf("rand_rst%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
